regfile_write_arbiter: RTL and testbench

Shares the single register-file write port (RegWrite / write_reg / write_data) between two writeback requesters, the ALU result path and the memory-load path. Requests that cannot use the port in the current cycle are held in a small in-order pending queue and drained one per cycle. Back-pressure is signalled upstream with per-requester acknowledges and a combined stall. Optional forwarding exposes pending write data to the rs/rt read addresses.

---
 rtl/regfile_write_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Shares one register-file write port between the ALU writeback path and the
// memory-load writeback path. Requests that cannot issue this cycle are held
// in an in-order circular pending queue that drains one entry per cycle.
// Optional feature macro: REGARB_FORWARD_EN (enables rs/rt forwarding lookup
// over in-flight writes; when undefined the fwd_* outputs are tied to zero).
module regfile_write_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_req,
    input  logic [ADDR_W-1:0] alu_reg,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ack,
    input  logic              mem_req,
    input  logic [ADDR_W-1:0] mem_reg,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ack,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic              stall,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic              fwd_a_hit,
    output logic              fwd_b_hit,
    output logic [DATA_W-1:0] fwd_a_data,
    output logic [DATA_W-1:0] fwd_b_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    // Write-port register
    logic              wp_vld_q, wp_vld_d;
    logic [ADDR_W-1:0] wp_reg_q, wp_reg_d;
    logic [DATA_W-1:0] wp_data_q, wp_data_d;

    // Pending queue (circular buffer)
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] q_reg_q  [DEPTH];
    logic [ADDR_W-1:0] q_reg_d  [DEPTH];
    logic [DATA_W-1:0] q_data_q [DEPTH];
    logic [DATA_W-1:0] q_data_d [DEPTH];

    logic mem_take, alu_take;

    // Pick the oldest candidate for the port and append the rest while space remains
    always_comb begin
        wp_vld_d  = 1'b0;
        wp_reg_d  = wp_reg_q;
        wp_data_d = wp_data_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        q_reg_d   = q_reg_q;
        q_data_d  = q_data_q;
        mem_take  = 1'b0;
        alu_take  = 1'b0;

        if (count_q != CNT_ZERO) begin
            // Non-empty queue always issues its head, freeing one slot.
            wp_vld_d  = 1'b1;
            wp_reg_d  = q_reg_q[head_q];
            wp_data_d = q_data_q[head_q];
            head_d    = head_q + PTR_ONE;
            count_d   = count_q - CNT_ONE;
            if (mem_req) begin
                mem_take         = 1'b1;
                q_reg_d[tail_d]  = mem_reg;
                q_data_d[tail_d] = mem_data;
                tail_d           = tail_d + PTR_ONE;
                count_d          = count_d + CNT_ONE;
            end
            if (alu_req && (count_d != CNT_FULL)) begin
                alu_take         = 1'b1;
                q_reg_d[tail_d]  = alu_reg;
                q_data_d[tail_d] = alu_data;
                tail_d           = tail_d + PTR_ONE;
                count_d          = count_d + CNT_ONE;
            end
        end else if (mem_req) begin
            // Mem goes first; a same-cycle alu write queues behind it so it lands last.
            mem_take  = 1'b1;
            wp_vld_d  = 1'b1;
            wp_reg_d  = mem_reg;
            wp_data_d = mem_data;
            if (alu_req) begin
                alu_take         = 1'b1;
                q_reg_d[tail_q]  = alu_reg;
                q_data_d[tail_q] = alu_data;
                tail_d           = tail_q + PTR_ONE;
                count_d          = CNT_ONE;
            end
        end else if (alu_req) begin
            alu_take  = 1'b1;
            wp_vld_d  = 1'b1;
            wp_reg_d  = alu_reg;
            wp_data_d = alu_data;
        end
    end

    // Acknowledges are suppressed while reset is held
    always_comb begin
        mem_ack = mem_take & ~reset;
        alu_ack = alu_take & ~reset;
        stall   = (mem_req & ~mem_ack) | (alu_req & ~alu_ack);
    end

    // Control and write-port state with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            wp_vld_q  <= 1'b0;
            wp_reg_q  <= '0;
            wp_data_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            wp_vld_q  <= wp_vld_d;
            wp_reg_q  <= wp_reg_d;
            wp_data_q <= wp_data_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

    // Queue payload storage; validity is tracked by the pointers and count only
    always_ff @(posedge clk) begin
        q_reg_q  <= q_reg_d;
        q_data_q <= q_data_d;
    end

    assign RegWrite   = wp_vld_q;
    assign write_reg  = wp_reg_q;
    assign write_data = wp_data_q;

`ifdef REGARB_FORWARD_EN
    // Walk in-flight writes oldest to youngest so the youngest match wins
    always_comb begin
        logic [PTR_W-1:0] idx;
        fwd_a_hit  = 1'b0;
        fwd_b_hit  = 1'b0;
        fwd_a_data = '0;
        fwd_b_data = '0;
        idx        = head_q;
        if (wp_vld_q && (wp_reg_q == rs)) begin
            fwd_a_hit  = 1'b1;
            fwd_a_data = wp_data_q;
        end
        if (wp_vld_q && (wp_reg_q == rt)) begin
            fwd_b_hit  = 1'b1;
            fwd_b_data = wp_data_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if (CNT_W'(i) < count_q) begin
                if (q_reg_q[idx] == rs) begin
                    fwd_a_hit  = 1'b1;
                    fwd_a_data = q_data_q[idx];
                end
                if (q_reg_q[idx] == rt) begin
                    fwd_b_hit  = 1'b1;
                    fwd_b_data = q_data_q[idx];
                end
            end
        end
    end
`else
    // Forwarding removed: outputs held at zero, addresses unused
    logic unused_fwd;
    assign unused_fwd = ^{rs, rt};
    assign fwd_a_hit  = 1'b0;
    assign fwd_b_hit  = 1'b0;
    assign fwd_a_data = '0;
    assign fwd_b_data = '0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Testbench for regfile_write_arbiter: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_regfile_write_arbiter;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] r;
        logic [DATA_W-1:0] d;
    } ent_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              alu_req, mem_req;
    logic [ADDR_W-1:0] alu_reg, mem_reg, rs, rt;
    logic [DATA_W-1:0] alu_data, mem_data;
    logic              alu_ack, mem_ack, RegWrite, stall;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic              fwd_a_hit, fwd_b_hit;
    logic [DATA_W-1:0] fwd_a_data, fwd_b_data;

    regfile_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .alu_req(alu_req), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ack(alu_ack),
        .mem_req(mem_req), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ack(mem_ack),
        .RegWrite(RegWrite), .write_reg(write_reg), .write_data(write_data),
        .stall(stall), .rs(rs), .rt(rt),
        .fwd_a_hit(fwd_a_hit), .fwd_b_hit(fwd_b_hit),
        .fwd_a_data(fwd_a_data), .fwd_b_data(fwd_b_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: pending writes in arrival order plus the write on the port
    ent_t pq[$];
    logic exp_vld = 1'b0;
    ent_t exp_wp  = '0;
    logic obs_mack, obs_aack, obs_stall;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fwd_expect(input logic [ADDR_W-1:0] a, output logic hit, output logic [DATA_W-1:0] d);
        hit = 1'b0;
        d   = '0;
`ifdef REGARB_FORWARD_EN
        for (int i = pq.size() - 1; i >= 0 && !hit; i--) begin
            if (pq[i].r == a) begin
                hit = 1'b1;
                d   = pq[i].d;
            end
        end
        if (!hit && exp_vld && exp_wp.r == a) begin
            hit = 1'b1;
            d   = exp_wp.d;
        end
`endif
    endtask

    // One clock cycle: drive inputs, check at negedge against the model, advance model
    task automatic do_cycle(input logic rst, input logic mr, input int mreg, input int mdata,
                            input logic ar, input int areg, input int adata,
                            input int a_rs, input int a_rt);
        ent_t cand[$];
        int   mi, ai;
        logic e_mack, e_aack, e_hit;
        logic [DATA_W-1:0] e_d;
        reset    = rst;
        mem_req  = mr;  mem_reg = ADDR_W'(mreg); mem_data = DATA_W'(mdata);
        alu_req  = ar;  alu_reg = ADDR_W'(areg); alu_data = DATA_W'(adata);
        rs       = ADDR_W'(a_rs);
        rt       = ADDR_W'(a_rt);
        @(negedge clk);
        cand = pq;
        mi = -1; ai = -1;
        if (mr) begin mi = cand.size(); cand.push_back({mem_reg, mem_data}); end
        if (ar) begin ai = cand.size(); cand.push_back({alu_reg, alu_data}); end
        e_mack = !rst && mr && (mi <= DEPTH);
        e_aack = !rst && ar && (ai <= DEPTH);
        obs_mack  = mem_ack;
        obs_aack  = alu_ack;
        obs_stall = stall;
        check("mem_ack", mem_ack, e_mack);
        check("alu_ack", alu_ack, e_aack);
        check("stall", stall, (mr && !e_mack) || (ar && !e_aack));
        check("RegWrite", RegWrite, exp_vld);
        if (exp_vld) begin
            check("write_reg", write_reg, exp_wp.r);
            check("write_data", write_data, exp_wp.d);
        end
        fwd_expect(rs, e_hit, e_d);
        check("fwd_a_hit", fwd_a_hit, e_hit);
        check("fwd_a_data", fwd_a_data, e_d);
        fwd_expect(rt, e_hit, e_d);
        check("fwd_b_hit", fwd_b_hit, e_hit);
        check("fwd_b_data", fwd_b_data, e_d);
        if (rst) begin
            pq.delete();
            exp_vld = 1'b0;
            exp_wp  = '0;
        end else begin
            exp_vld = (cand.size() > 0);
            if (exp_vld) exp_wp = cand.pop_front();
            pq.delete();
            while (cand.size() > 0 && pq.size() < DEPTH) pq.push_back(cand.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 0, 0);
    endtask

    initial begin
        logic hold_m, hold_a;
        int mreg_v, mdata_v, areg_v, adata_v;
        logic mr_v, ar_v;

        // Reset and idle state
        do_cycle(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 0, 0);
        do_cycle(1'b1, 1'b1, 1, 1, 1'b1, 2, 2, 0, 0);
        check("rst_regwrite", RegWrite, 1'b0);
        check("rst_write_reg", write_reg, 0);
        check("rst_write_data", write_data, 0);
        idle(1);

        // Single ALU write, 1-cycle latency, one-cycle pulse
        do_cycle(1'b0, 1'b0, 0, 0, 1'b1, 3, 32'h5, 0, 0);
        check("t1_ack", obs_aack, 1'b1);
        check("t1_we", RegWrite, 1'b1);
        check("t1_reg", write_reg, 3);
        check("t1_data", write_data, 32'h5);
        idle(1);
        check("t1_we_off", RegWrite, 1'b0);

        // Simultaneous mem and alu to different registers
        do_cycle(1'b0, 1'b1, 4, 32'hA, 1'b1, 5, 32'hB, 0, 0);
        check("t2_both_ack", {obs_mack, obs_aack}, 2'b11);
        check("t2_first", write_reg, 4);
        idle(1);
        check("t2_second", write_reg, 5);
        idle(1);

        // Same-destination collision: mem then alu
        do_cycle(1'b0, 1'b1, 2, 32'h1, 1'b1, 2, 32'h2, 0, 0);
        check("t3_first", write_data, 32'h1);
        idle(1);
        check("t3_second", write_data, 32'h2);
        idle(1);

        // Both requesters for 4 cycles; alu holds while not acked
        areg_v = 10; adata_v = 32'h100;
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b0, 1'b1, 20 + i, 32'h200 + i, 1'b1, areg_v, adata_v, 0, 0);
            if (i == 0) check("t4_first_both", {obs_mack, obs_aack}, 2'b11);
            if (i >= 2) check("t4_full_stall", {obs_mack, obs_aack, obs_stall}, 3'b101);
            if (obs_aack) begin areg_v++; adata_v++; end
        end
        idle(4);

        // Forwarding: two queued writes to reg 7
        do_cycle(1'b0, 1'b1, 1, 32'h1, 1'b1, 9, 32'h9, 0, 0);
        do_cycle(1'b0, 1'b1, 7, 32'h11, 1'b1, 7, 32'h22, 7, 7);
        do_cycle(1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 7, 3);
`ifdef REGARB_FORWARD_EN
        // checked inside the next cycle below as well
`endif
        idle(3);

        // Reset with two entries queued
        do_cycle(1'b0, 1'b1, 12, 32'hC, 1'b1, 13, 32'hD, 0, 0);
        do_cycle(1'b0, 1'b1, 14, 32'hE, 1'b1, 15, 32'hF, 0, 0);
        do_cycle(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 0, 0);
        check("t6_we_after_rst", RegWrite, 1'b0);
        idle(2);
        check("t6_no_stale", RegWrite, 1'b0);
        do_cycle(1'b0, 1'b0, 0, 0, 1'b1, 6, 32'h66, 0, 0);
        check("t6_new_we", RegWrite, 1'b1);
        check("t6_new_data", write_data, 32'h66);

        // Randomized traffic with hold-until-ack discipline and occasional reset
        hold_m = 1'b0; hold_a = 1'b0;
        mr_v = 1'b0; ar_v = 1'b0;
        mreg_v = 0; mdata_v = 0; areg_v = 0; adata_v = 0;
        for (int i = 0; i < 600; i++) begin
            logic rst_v;
            rst_v = ($urandom_range(0, 59) == 0);
            if (!hold_m) begin
                mr_v = ($urandom_range(0, 3) != 0);
                mreg_v = $urandom_range(0, 7);
                mdata_v = $urandom;
            end
            if (!hold_a) begin
                ar_v = ($urandom_range(0, 3) != 0);
                areg_v = $urandom_range(0, 7);
                adata_v = $urandom;
            end
            do_cycle(rst_v, mr_v, mreg_v, mdata_v, ar_v, areg_v, adata_v,
                     $urandom_range(0, 7), $urandom_range(0, 7));
            hold_m = mr_v && !obs_mack;
            hold_a = ar_v && !obs_aack;
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
